user_code_loader: RTL and testbench

- Loads user program words into the CPU's 32-entry instruction code memory (low bank: addresses 0-15, high bank: addresses 16-31) from an 8-bit byte stream.
- Arbitrates the code memory address port between CPU instruction fetch and the loader.
- Holds the CPU (cpu_hold) for the whole load and signals completion, abort or bad requests.

---
 rtl/user_code_loader.sv | 123 ++++++++++++
 tb/tb_user_code_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_code_loader.sv
// Byte-stream loader for the 32-word instruction code memory.
// It shares the memory address port with CPU fetch and holds the CPU while a load runs.
module user_code_loader #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        state_dbg    // 0 IDLE, 1 HI, 2 LO, 3 WRITE, 4 DONE
);

  // Byte handshake: a byte moves on a rising clock edge when byte_valid && byte_ready.
  // byte_ready is high only in HI/LO and is masked by abort, so an aborting cycle takes no byte.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   n_target;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        hi_byte, lo_byte;
  logic              legal_req;
  logic              last_word;
  logic [ADDR_W:0]   count_nxt;

  assign legal_req = (num_words != '0) && (num_words <= DEPTH);
  assign count_nxt = words_loaded + (ADDR_W + 1)'(1);
  assign last_word = (count_nxt == n_target);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && legal_req) state_nxt = S_HI;
      S_HI:    if (abort) state_nxt = S_IDLE;
               else if (byte_valid) state_nxt = S_LO;
      S_LO:    if (abort) state_nxt = S_IDLE;
               else if (byte_valid) state_nxt = S_WRITE;
      S_WRITE: if (abort) state_nxt = S_IDLE;
               else if (last_word) state_nxt = S_DONE;
               else state_nxt = S_HI;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    cpu_hold   = (state != S_IDLE);
    case (state)
      S_HI, S_LO: byte_ready = !abort;
      S_WRITE:    mem_we = 1'b1;
      S_DONE:     done = 1'b1;
      default:    ;
    endcase
  end

  // The write in WRITE always completes, even when abort is raised in that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_target     <= '0;
      wr_addr      <= '0;
      hi_byte      <= '0;
      lo_byte      <= '0;
      words_loaded <= '0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (legal_req) begin
            n_target     <= num_words;
            wr_addr      <= '0;
            words_loaded <= '0;
            error        <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end
        S_HI:    if (byte_valid && byte_ready) hi_byte <= byte_in;
        S_LO:    if (byte_valid && byte_ready) lo_byte <= byte_in;
        S_WRITE: begin
          words_loaded <= count_nxt;
          if (!last_word) wr_addr <= wr_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = (state == S_IDLE) ? fetch_addr : wr_addr;
  assign mem_wdata = {hi_byte, lo_byte};
  assign state_dbg = state;

endmodule

// File: tb/tb_user_code_loader.sv
// Bench for user_code_loader: directed and randomized loads against a queue of expected
// (address, word) writes built from the byte stream and word count.
module tb_user_code_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  num_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  fetch_addr;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  words_loaded;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  bit prev_done = 1'b0;
  logic [20:0] exp_q[$];
  int          wr_cyc_q[$];
  logic [20:0] exp_e;
  logic [7:0]  bytes_a[64];

  user_code_loader #(.ADDR_W(5), .WORD_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fetch_addr(fetch_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  // Scoreboard: every write must match the head of exp_q; idle cycles must route fetch_addr.
  always @(negedge clock) begin
    cyc_n++;
    if (!reset) begin
      if (!cpu_hold) check("arb", mem_addr, fetch_addr);
      if (prev_done) check("hold_drop", cpu_hold, 0);
      prev_done = done;
      if (done) done_cnt++;
      if (mem_we) begin
        wr_cyc_q.push_back(cyc_n);
        if (exp_q.size() == 0) check("unexp_we", mem_we, 0);
        else begin
          exp_e = exp_q.pop_front();
          check("wr", {mem_addr, mem_wdata}, exp_e);
        end
      end
    end
  end

  // mode 0: byte_valid held high, 1: toggles every other cycle, 2: random gaps
  task automatic run_load(input int n, input int mode, input bit preset);
    int idx;
    int budget;
    if (!preset) for (int i = 0; i < 2 * n; i++) bytes_a[i] = 8'($urandom);
    for (int i = 0; i < n; i++) exp_q.push_back({5'(i), bytes_a[2 * i], bytes_a[2 * i + 1]});
    done_cnt = 0;
    wr_cyc_q.delete();
    num_words = 6'(n);
    start = 1'b1;
    start_cyc = cyc_n;
    cyc();
    start = 1'b0;
    num_words = 6'($urandom);
    idx = 0;
    budget = 0;
    while (idx < 2 * n && budget < 2000) begin
      check("hold_in_load", cpu_hold, 1);
      fetch_addr = 5'($urandom);
      byte_in = bytes_a[idx];
      case (mode)
        0: byte_valid = 1'b1;
        1: byte_valid = (budget % 2 == 0);
        default: byte_valid = ($urandom_range(0, 99) >= 35);
      endcase
      if (byte_valid && byte_ready) idx++;
      cyc();
      budget++;
    end
    byte_valid = 1'b0;
    budget = 0;
    while (cpu_hold && budget < 20) begin
      cyc();
      budget++;
    end
    check("load_end_hold", cpu_hold, 0);
    check("done_cnt", done_cnt, 1);
    check("words_loaded", words_loaded, n);
    check("exp_empty", exp_q.size(), 0);
  endtask

  // Three-word load with byte_valid held high; abort in LO (cycle 5) or WRITE (cycle 6) of word 2.
  task automatic run_abort(input bit in_write);
    int idx;
    int ab_k;
    for (int i = 0; i < 6; i++) bytes_a[i] = 8'($urandom);
    exp_q.push_back({5'd0, bytes_a[0], bytes_a[1]});
    if (in_write) exp_q.push_back({5'd1, bytes_a[2], bytes_a[3]});
    ab_k = in_write ? 6 : 5;
    done_cnt = 0;
    num_words = 6'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    idx = 0;
    byte_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == ab_k + 1) check("abort_idle", cpu_hold, 0);
      byte_in = bytes_a[idx];
      abort = (k == ab_k);
      if (byte_valid && byte_ready) idx++;
      cyc();
    end
    abort = 1'b0;
    byte_valid = 1'b0;
    check("abort_hold", cpu_hold, 0);
    check("abort_done", done_cnt, 0);
    check("abort_words", words_loaded, in_write ? 2 : 1);
    check("abort_exp", exp_q.size(), 0);
    check("abort_err", error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0; fetch_addr = '0;
    cyc();
    cyc();
    check("rst_ready", byte_ready, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_words", words_loaded, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    cyc();

    // reset during LO of the first word
    num_words = 6'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    cyc();
    check("pre_rst_hold", cpu_hold, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_words", words_loaded, 0);
    byte_valid = 1'b0;
    exp_q.delete();
    cyc();
    reset = 1'b0;
    fetch_addr = 5'd7;
    cyc();
    check("post_rst_addr", mem_addr, 7);
    check("post_rst_hold", cpu_hold, 0);

    // directed three-word load, bytes back to back
    bytes_a[0] = 8'h80; bytes_a[1] = 8'h00; bytes_a[2] = 8'h84;
    bytes_a[3] = 8'h01; bytes_a[4] = 8'h11; bytes_a[5] = 8'h02;
    run_load(3, 0, 1'b1);
    check("wr_count3", wr_cyc_q.size(), 3);
    for (int i = 0; i < wr_cyc_q.size(); i++) check("wr_cycle", wr_cyc_q[i] - start_cyc, 3 * (i + 1));

    // single word with a gappy stream
    run_load(1, 1, 1'b0);

    // illegal sizes, then a legal start clears error
    for (int i = 0; i < 2; i++) begin
      num_words = (i == 0) ? 6'd0 : 6'd33;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      check("illegal_err", error, 1);
      check("illegal_hold", cpu_hold, 0);
      check("illegal_busy", busy, 0);
    end
    run_load(2, 2, 1'b0);
    check("err_clr", error, 0);

    // full 32-word load, then random sizes
    run_load(32, 2, 1'b0);
    for (int r = 0; r < 6; r++) run_load($urandom_range(1, 32), 2, 1'b0);

    run_abort(1'b0);
    run_abort(1'b1);
    run_load(4, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
